mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store stage directly upstream of the single-port data RAM in the RV32I core.
- Accepts byte-addressed load/store requests from the execute stage and drives the RAM word port.
- The RAM has no byte enables, so SB/SH are done as read-modify-write. Loads are lane-extracted with sign or zero extension.
- Misaligned accesses and illegal funct3 are reported as errors and never touch the RAM.

Parameters:
- DATA_WIDTH, 32, RAM word width; only 32 is supported.
- ADDR_BITS, 10, RAM word-address width, i.e. the depth is 2^ADDR_BITS words.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse, for loads and stores
- rsp_err  out  1  qualifies rsp_valid: misaligned or illegal access
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- ram_addr  out  ADDR_BITS  equals req_addr[ADDR_BITS+1:2], or the held address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, valid the cycle after a read
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable

Behaviour:
- States: IDLE, LD_DATA, RMW_MERGE. After rst the state is IDLE.
- Reset values: rsp_valid=0, rsp_err=0, rsp_rdata=0. While rst is high, req_ready=0, ram_en=0 and ram_we=0.
- req_ready = (state==IDLE) && !rst. The ram_* outputs are combinational from the state and the request.
- On accept, addr/funct3/wdata are captured into holding registers.
- Error check on accept:
  - Illegal funct3: 011, 11x, or 10x with req_we=1.
  - Misaligned: H with addr[0]=1, or W with addr[1:0]!=0.
  - On error: ram_en=0, stay in IDLE, next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Load, legal:
  - Accept cycle: ram_en=1, ram_we=0. Go to LD_DATA.
  - LD_DATA: select the lane from ram_dout using held addr[1:0]. B/H are sign-extended, BU/HU zero-extended, W passes through. Register into rsp_rdata and go to IDLE.
  - Next cycle: rsp_valid=1.
  - Latency 2 cycles from accept to rsp_valid; throughput 1 load per 2 cycles.
- SW, legal:
  - Accept cycle: ram_en=1, ram_we=1, ram_din=req_wdata. Stay in IDLE.
  - Next cycle: rsp_valid=1. Back-to-back SW is accepted every cycle.
- SB/SH, legal:
  - Accept cycle: ram_en=1, ram_we=0. Go to RMW_MERGE.
  - RMW_MERGE: ram_en=1, ram_we=1, ram_addr=held address. ram_din is ram_dout with the lane replaced: byte lane addr[1:0] gets wdata[7:0]; half lane addr[1] gets wdata[15:0]. Go to IDLE.
  - Next cycle: rsp_valid=1. Latency 2 cycles.
- A new request may be accepted in the same cycle rsp_valid is high (state is IDLE).
- ram_addr wraps: address bits above ADDR_BITS+1 are ignored.
- req_* must be held while req_valid && !req_ready. Outputs are ignored in that case.
- rst during LD_DATA: the load is dropped and no rsp_valid is produced.
- rst during RMW_MERGE: the write is not issued (ram_en=0), the memory word is unchanged, and no rsp_valid is produced.
- A pending rsp_valid is cleared by rst.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 2 cycles after the LW accept, rdata=0xDEADBEEF, err=0.
- Word 0x11223344 at 0x20:
  - LB 0x23 -> 0x00000011.
  - SB 0x21 data 0x000000F0, then LB 0x21 -> 0xFFFFFFF0, LBU 0x21 -> 0x000000F0.
  - LW 0x20 -> 0x1122F044.
- SH 0x22 data 0x8001 onto 0x11223344, then LH 0x22 -> 0xFFFF8001, LHU -> 0x00008001, LW -> 0x80013344; req_ready low exactly one cycle per SH.
- LH 0x31, SW 0x32, funct3 011 -> each gives rsp_valid=1, rsp_err=1, rdata=0; ram_en never asserted; memory unchanged.
- SB 0x40 with rst asserted during RMW_MERGE -> no RAM write, no rsp_valid; a later LW 0x40 returns the original word.
- Four consecutive SW with req_valid held high -> req_ready stays 1, one rsp_valid per cycle, all four words read back correctly.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a single-port word RAM without byte enables.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [ADDR_BITS-1:0]  ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_en,
    output logic                  ram_we
);

    typedef enum logic [1:0] {IDLE, LD_DATA, RMW_MERGE} state_t;

    state_t               state, state_nxt;
    logic [ADDR_BITS+1:0] addr_p0;
    logic [2:0]           funct3_p0;
    logic [15:0]          wdata_p0;
    logic                 accept, illegal, misaligned, req_err, is_sw;
    logic                 unused_addr_hi;

    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [2:0]            f3
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [DATA_WIDTH-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {{(DATA_WIDTH-8){1'b0}}, b} : {{(DATA_WIDTH-8){b[7]}}, b};
            2'b01:   r = f3[2] ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-16){h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic                  is_byte,
        input logic [15:0]           wdata
    );
        logic [DATA_WIDTH-1:0] r;
        r = word;
        if (is_byte)
            r[{off, 3'b000} +: 8] = wdata[7:0];
        else if (off[1])
            r[31:16] = wdata;
        else
            r[15:0] = wdata;
        return r;
    endfunction

    assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    // 10x is BU/HU, which only exists as a load.
    assign illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                        ((req_funct3[2:1] == 2'b10) && req_we);
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_err    = illegal || misaligned;
    assign is_sw      = req_we && (req_funct3 == 3'b010);

    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = req_addr[ADDR_BITS+1:2];
        ram_din   = req_wdata;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (accept && !req_err) begin
                        ram_en = 1'b1;
                        if (is_sw)
                            ram_we = 1'b1;
                        else if (req_we)
                            state_nxt = RMW_MERGE;
                        else
                            state_nxt = LD_DATA;
                    end
                end
                LD_DATA: begin
                    ram_addr  = addr_p0[ADDR_BITS+1:2];
                    state_nxt = IDLE;
                end
                RMW_MERGE: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = addr_p0[ADDR_BITS+1:2];
                    ram_din   = store_merge(ram_dout, addr_p0[1:0], funct3_p0[1:0] == 2'b00, wdata_p0);
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage p0: request capture and response registers
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0   <= req_addr[ADDR_BITS+1:0];
            funct3_p0 <= req_funct3;
            wdata_p0  <= req_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= (accept && (req_err || is_sw)) || (state == LD_DATA) || (state == RMW_MERGE);
            rsp_err   <= accept && req_err;
            rsp_rdata <= (state == LD_DATA) ? load_extract(ram_dout, addr_p0[1:0], funct3_p0) : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural synchronous RAM.
module tb_mem_access_unit;

    localparam logic [2:0] F_B = 3'd0, F_H = 3'd1, F_W = 3'd2, F_BU = 3'd4, F_HU = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic        ram_en, ram_we;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_en(ram_en), .ram_we(ram_we)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    int cyc = 0;
    int n_writes = 0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        ram_dout = 32'h0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                n_writes      <= n_writes + 1;
            end
            ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check32("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check32("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                check32("rsp_rdata", rsp_rdata, e.rdata);
                check32("rsp_latency", cyc, e.due);
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                          input bit expect_rsp);
        int tries;
        int lat;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        tries = 0;
        while (!req_ready && tries < 20) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!req_ready) begin
            check32("accept_timeout", {31'b0, req_ready}, 32'h1);
            return;
        end
        if (err) check32("err_no_ram_en", {31'b0, ram_en}, 32'h0);
        lat = (err || (we && f3 == F_W)) ? 1 : 2;
        if (expect_rsp) sb.push_back('{err, rdata, cyc + lat});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int w0;
        tbl.push_back('{1'b1, F_W,  32'h10,   32'hDEADBEEF, 1'b0, 32'h0});
        tbl.push_back('{1'b0, F_W,  32'h10,   32'h0,        1'b0, 32'hDEADBEEF});
        tbl.push_back('{1'b1, F_W,  32'h20,   32'h11223344, 1'b0, 32'h0});
        tbl.push_back('{1'b0, F_B,  32'h23,   32'h0,        1'b0, 32'h00000011});
        tbl.push_back('{1'b0, F_BU, 32'h20,   32'h0,        1'b0, 32'h00000044});
        tbl.push_back('{1'b1, F_B,  32'h21,   32'h000000F0, 1'b0, 32'h0});
        tbl.push_back('{1'b0, F_B,  32'h21,   32'h0,        1'b0, 32'hFFFFFFF0});
        tbl.push_back('{1'b0, F_BU, 32'h21,   32'h0,        1'b0, 32'h000000F0});
        tbl.push_back('{1'b0, F_W,  32'h20,   32'h0,        1'b0, 32'h1122F044});
        tbl.push_back('{1'b0, F_H,  32'h20,   32'h0,        1'b0, 32'hFFFFF044});
        tbl.push_back('{1'b1, F_W,  32'h30,   32'hCAFEF00D, 1'b0, 32'h0});
        tbl.push_back('{1'b0, F_H,  32'h31,   32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, F_W,  32'h32,   32'h12345678, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 3'd3, 32'h30,   32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 3'd3, 32'h30,   32'h55555555, 1'b1, 32'h0});
        tbl.push_back('{1'b1, F_BU, 32'h30,   32'h000000FF, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 3'd6, 32'h30,   32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, F_H,  32'h33,   32'h0000FFFF, 1'b1, 32'h0});
        tbl.push_back('{1'b0, F_W,  32'h30,   32'h0,        1'b0, 32'hCAFEF00D});
        tbl.push_back('{1'b1, F_W,  32'h1010, 32'h12345678, 1'b0, 32'h0});
        tbl.push_back('{1'b0, F_W,  32'h10,   32'h0,        1'b0, 32'h12345678});
        tbl.push_back('{1'b1, F_W,  32'h20,   32'h11223344, 1'b0, 32'h0});

        // Reset, with a store presented to prove nothing is accepted.
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F_W;
        req_addr   = 32'h10;
        req_wdata  = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        #1;
        check32("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check32("rst_ram_en",    {31'b0, ram_en},    32'h0);
        check32("rst_ram_we",    {31'b0, ram_we},    32'h0);
        check32("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check32("rst_rsp_err",   {31'b0, rsp_err},   32'h0);
        check32("rst_rsp_rdata", rsp_rdata,          32'h0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;

        foreach (tbl[i])
            do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rdata, 1'b1);
        idle();

        // SH read-modify-write: ready drops for exactly the merge cycle.
        do_req(1'b1, F_H, 32'h22, 32'h00008001, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check32("sh_ready_low", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        #1;
        check32("sh_ready_back", {31'b0, req_ready}, 32'h1);
        do_req(1'b0, F_H,  32'h22, 32'h0, 1'b0, 32'hFFFF8001, 1'b1);
        do_req(1'b0, F_HU, 32'h22, 32'h0, 1'b0, 32'h00008001, 1'b1);
        do_req(1'b0, F_W,  32'h20, 32'h0, 1'b0, 32'h80013344, 1'b1);

        // Reset while the SB merge is pending: no write, no response.
        do_req(1'b1, F_W, 32'h40, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1);
        do_req(1'b1, F_B, 32'h40, 32'h00000011, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        w0        = n_writes;
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check32("rst_rmw_no_write", n_writes, w0);
        do_req(1'b0, F_W, 32'h40, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);
        idle();

        // Four back-to-back SW with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = F_W;
            req_addr   = 32'h50 + 32'(i * 4);
            req_wdata  = 32'hB0B0_0000 + 32'(i);
            #1;
            check32("b2b_ready", {31'b0, req_ready}, 32'h1);
            sb.push_back('{1'b0, 32'h0, cyc + 1});
            @(posedge clk);
        end
        for (int i = 0; i < 4; i++)
            do_req(1'b0, F_W, 32'h50 + 32'(i * 4), 32'h0, 1'b0, 32'hB0B0_0000 + 32'(i), 1'b1);
        idle();

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        check32("drain", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
